// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: handshaked integer ALU for the EX stage.
//   Base RV32I ALU ops (codes 00-09) finish in 1 cycle. With ALU_SEQ_MULDIV_EN
//   defined, MUL* (0A-0D) take 2 cycles and DIV*/REM* (0E-11) take XLEN+1
//   cycles. Without the macro, codes 0A-11 are reported as illegal and the
//   multiplier/divider are not built.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   alu_control         5-bit op code
//   operand_a/operand_b XLEN-bit operands, latched on accept
//   flush               abort in-flight op / drop pending result
//   out_valid/out_ready result handshake
//   result, zero        registered result and (result == 0)
//   illegal             unsupported op code, qualified by out_valid
module alu_seq_muldiv #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd3} state_t;
`endif

    state_t state_q, state_d;
    logic            accept, is_base, is_legal, load;
    logic [XLEN-1:0] base_res, res_d;
    logic            ill_d;
    logic [SHAMT_W-1:0] shamt;

    // Keep in_ready low while reset is asserted so it first rises after release.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready && !flush;
    assign shamt     = operand_b[SHAMT_W-1:0];
    assign is_base   = (alu_control <= 5'h09);

    always_comb begin
        base_res = '0;
        case (alu_control)
            5'h00: base_res = operand_a & operand_b;
            5'h01: base_res = operand_a | operand_b;
            5'h02: base_res = operand_a + operand_b;
            5'h03: base_res = operand_a << shamt;
            5'h04: base_res = operand_a ^ operand_b;
            5'h05: base_res = operand_a >> shamt;
            5'h06: base_res = operand_a - operand_b;
            5'h07: base_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            5'h08: base_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            5'h09: base_res = $signed(operand_a) >>> shamt;
            default: base_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic is_mul, is_div, div_signed, div_rem, div_zero, div_ovf, special;
    logic [XLEN-1:0]   sp_res, abs_a, abs_b;
    logic [2*XLEN-1:0] mul_ax, mul_bx;
    logic [2*XLEN-1:0] prod_q;
    logic              mul_hi_q, rem_op_q, neg_q, neg_r;
    logic [XLEN-1:0]   dvs_q, rem_q, quo_q, rem_nx, quo_nx, div_final;
    logic [SHAMT_W-1:0] cnt_q;
    logic [XLEN:0]     rem_sh, diff;

    assign is_mul     = alu_control inside {[5'h0A:5'h0D]};
    assign is_div     = alu_control inside {[5'h0E:5'h11]};
    assign div_signed = (alu_control == 5'h0E) || (alu_control == 5'h10);
    assign div_rem    = (alu_control == 5'h10) || (alu_control == 5'h11);
    assign div_zero   = (operand_b == '0);
    assign div_ovf    = div_signed && (operand_a == MIN_VAL) && (operand_b == '1);
    assign special    = div_zero || div_ovf;
    assign sp_res     = div_zero ? (div_rem ? operand_a : '1)
                                 : (div_rem ? '0 : MIN_VAL);
    assign is_legal   = is_base || is_mul || is_div;

    // Operands extended to 2*XLEN so one unsigned multiply covers all MUL* ops
    // (two's complement product is exact modulo 2^(2*XLEN)).
    assign mul_ax = (alu_control == 5'h0D) ? {{XLEN{1'b0}}, operand_a}
                                           : {{XLEN{operand_a[XLEN-1]}}, operand_a};
    assign mul_bx = (alu_control == 5'h0B) ? {{XLEN{operand_b[XLEN-1]}}, operand_b}
                                           : {{XLEN{1'b0}}, operand_b};

    assign abs_a = (div_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
    assign abs_b = (div_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;

    // One restoring step: shift next dividend bit into the partial remainder,
    // subtract if it fits; the borrow bit decides.
    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_sh - {1'b0, dvs_q};
    assign rem_nx    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nx    = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign div_final = rem_op_q ? (neg_r ? -rem_nx : rem_nx)
                                : (neg_q ? -quo_nx : quo_nx);
`else
    assign is_legal = is_base;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        res_d   = '0;
        ill_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
                if (is_mul) begin
                    state_d = MUL;
                end else if (is_div && !special) begin
                    state_d = DIV;
                end else begin
                    state_d = DONE;
                    load    = 1'b1;
                    ill_d   = !is_legal;
                    res_d   = !is_legal ? '0 : (is_div ? sp_res : base_res);
                end
`else
                state_d = DONE;
                load    = 1'b1;
                ill_d   = !is_legal;
                res_d   = is_legal ? base_res : '0;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            MUL: if (flush) begin
                state_d = IDLE;
            end else begin
                state_d = DONE;
                load    = 1'b1;
                res_d   = mul_hi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
            end
            DIV: if (flush) begin
                state_d = IDLE;
            end else if (cnt_q == '0) begin
                state_d = DONE;
                load    = 1'b1;
                res_d   = div_final;
            end
`endif
            DONE: if (flush || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                result  <= res_d;
                zero    <= (res_d == '0);
                illegal <= ill_d;
            end
        end
    end

`ifdef ALU_SEQ_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            mul_hi_q <= 1'b0;
            rem_op_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == IDLE && accept) begin
            prod_q   <= mul_ax * mul_bx;
            mul_hi_q <= (alu_control != 5'h0A);
            rem_op_q <= div_rem;
            neg_q    <= div_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
            neg_r    <= div_signed && operand_a[XLEN-1];
            dvs_q    <= abs_b;
            quo_q    <= abs_a;
            rem_q    <= '0;
            cnt_q    <= SHAMT_W'(XLEN-1);
        end else if (state_q == DIV) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end
`endif

endmodule
